// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial word deserializer.
package serial_deser_pkg;

    // Receive FSM: IDLE while no partial word is held, RECV while bits are being collected.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Fill direction latched on the first bit of each frame.
    localparam logic MODE_LSB_FIRST = 1'b0;
    localparam logic MODE_MSB_FIRST = 1'b1;

endpackage

// File: rtl/word_hold_buf.sv
// One-word holding buffer with valid/ready output and sticky overrun flag.
// A load while the buffer is full and not being drained drops the new word.
module word_hold_buf
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_drain;
    logic             w_room;

    assign w_drain = r_valid & out_ready;
    assign w_room  = (~r_valid) | out_ready;

    // Hold the word, take a new one when there is room, and flag a dropped word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data    <= {WIDTH{1'b0}};
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (load && w_room) begin
                r_data  <= load_data;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end

            // A set in the same cycle as a clear must win.
            if (load && !w_room) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler: collects WIDTH bits MSB- or LSB-first
// and hands each completed word to a one-word valid/ready holding buffer.
module serial_word_deserializer
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_valid,
    input  logic             ser_data,
    input  logic             frame_start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_busy;

    logic             w_first;
    logic             w_mode;
    logic [WIDTH-1:0] w_sr_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_complete;

    // Next shift value and bit count for the bit currently on ser_data.
    always_comb begin
        w_first    = (r_state == IDLE) | frame_start;
        w_mode     = w_first ? msb_first : r_mode;
        w_sr_next  = (w_mode == MODE_MSB_FIRST) ? {r_sr[WIDTH-2:0], ser_data}
                                                : {ser_data, r_sr[WIDTH-1:1]};
        w_cnt_next = w_first ? CNT_W'(1) : (r_cnt + CNT_W'(1));
        if (ser_valid && (w_cnt_next == CNT_W'(WIDTH))) begin
            w_complete = 1'b1;
        end else begin
            w_complete = 1'b0;
        end
    end

    // Receive FSM: shift in qualified bits, restart on frame_start, finish on the last bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sr    <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_mode  <= MODE_LSB_FIRST;
            r_busy  <= 1'b0;
        end else if (ser_valid) begin
            r_sr   <= w_sr_next;
            r_mode <= w_mode;
            case (w_complete)
                1'b1: begin
                    r_state <= IDLE;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= RECV;
                    r_cnt   <= w_cnt_next;
                    r_busy  <= 1'b1;
                end
            endcase
        end else begin
            r_state <= r_state;
            r_sr    <= r_sr;
            r_cnt   <= r_cnt;
            r_mode  <= r_mode;
            r_busy  <= r_busy;
        end
    end

    assign busy = r_busy;

    word_hold_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (w_complete),
        .load_data  (w_sr_next),
        .out_ready  (out_ready),
        .clr_overrun(clr_overrun),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer (WIDTH=4).
module tb_serial_word_deserializer;

    logic       clk;
    logic       reset;
    logic       ser_valid;
    logic       ser_data;
    logic       frame_start;
    logic       msb_first;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
    logic       clr_overrun;

    int         n_checks;
    int         n_pass;
    logic [3:0] exp_q[$];

    serial_word_deserializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .frame_start(frame_start),
        .msb_first  (msb_first),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop and compare every word the consumer accepts.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {28'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("word", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs, input logic msb);
        ser_valid   = 1'b1;
        ser_data    = b;
        frame_start = fs;
        msb_first   = msb;
        tick();
        ser_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] bits, input logic msb);
        for (int i = 3; i >= 0; i--) send_bit(bits[i], 1'b0, msb);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b0;
        ser_valid = 1'b0;
        ser_data = 1'b0;
        frame_start = 1'b0;
        msb_first = 1'b0;
        out_ready = 1'b1;
        clr_overrun = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        tick();

        // MSB-first 0,1,1,0 -> 0110, valid for one cycle.
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 1'b1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {28'd0, out_data}, 32'h6);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("t1_overrun", {31'd0, overrun}, 32'd0);

        // LSB-first 0,0,1,1 -> 1100.
        exp_q.push_back(4'b1100);
        send_word(4'b0011, 1'b0);
        chk("t2_data", {28'd0, out_data}, 32'hC);
        tick();

        // LSB-first 1,0,gap,1,0 -> 0101.
        exp_q.push_back(4'b0101);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_gap_busy", {31'd0, busy}, 32'd1);
            chk("t2_gap_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("t2b_data", {28'd0, out_data}, 32'h5);
        tick();

        // Restart: 1,1 then frame_start with 1,0,0,1 -> single word 1001.
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        exp_q.push_back(4'b1001);
        send_bit(1'b1, 1'b1, 1'b1);
        chk("t3_busy_restart", {31'd0, busy}, 32'd1);
        chk("t3_valid_restart", {31'd0, out_valid}, 32'd0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        chk("t3_data", {28'd0, out_data}, 32'h9);
        tick();
        chk("t3_overrun", {31'd0, overrun}, 32'd0);

        // Backpressure: second word dropped, overrun set, then cleared.
        out_ready = 1'b0;
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 1'b1);
        send_word(4'b1111, 1'b1);
        chk("t4_data_held", {28'd0, out_data}, 32'h6);
        chk("t4_overrun", {31'd0, overrun}, 32'd1);
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("t4_overrun_clr", {31'd0, overrun}, 32'd0);
        chk("t4_valid_kept", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t4_valid_drop", {31'd0, out_valid}, 32'd0);

        // Drain and complete at the same edge: no bubble, no overrun.
        out_ready = 1'b0;
        exp_q.push_back(4'b0110);
        send_word(4'b0110, 1'b1);
        exp_q.push_back(4'b1010);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b1);
        chk("t5_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_data", {28'd0, out_data}, 32'hA);
        chk("t5_overrun", {31'd0, overrun}, 32'd0);
        tick();

        // Reset mid-frame discards the partial word.
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        exp_q.push_back(4'b1100);
        send_word(4'b1100, 1'b1);
        chk("t6_data", {28'd0, out_data}, 32'hC);
        tick();
        tick();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
